// File: rtl/snake_pkg.sv
// Shared types for the snake body engine.
//   dir_t   : step direction encoding (+x, -x, +y, -y)
//   coord_t : packed {x,y} coordinate at the default coordinate width
//   state_t : engine sequencing states
package snake_pkg;

  localparam int unsigned COORD_W = 6;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_NX = 2'd1,
    DIR_PY = 2'd2,
    DIR_NY = 2'd3
  } dir_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RESULT = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/snake_body_engine_if.sv
// Request/result bundle between the game controller / renderer (master)
// and the snake body engine (slave).
//   step_valid/step_ready/step_dir/step_grow : move requests
//   q_valid/q_x/q_y                          : occupancy queries
//   r_valid/r_is_step/r_wall/r_self          : one-cycle result pulse
//   head_x/head_y/length/dead                : snake status
interface snake_body_engine_if #(
  parameter int unsigned COORD_W = snake_pkg::COORD_W,
  parameter int unsigned LEN_W   = 7
);
  logic               step_valid;
  logic               step_ready;
  logic [1:0]         step_dir;
  logic               step_grow;
  logic               q_valid;
  logic [COORD_W-1:0] q_x;
  logic [COORD_W-1:0] q_y;
  logic               r_valid;
  logic               r_is_step;
  logic               r_wall;
  logic               r_self;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [LEN_W-1:0]   length;
  logic               dead;

  modport master (
    output step_valid, step_dir, step_grow, q_valid, q_x, q_y,
    input  step_ready, r_valid, r_is_step, r_wall, r_self,
           head_x, head_y, length, dead
  );

  modport slave (
    input  step_valid, step_dir, step_grow, q_valid, q_x, q_y,
    output step_ready, r_valid, r_is_step, r_wall, r_self,
           head_x, head_y, length, dead
  );
endinterface

// File: rtl/snake_scan_lanes.sv
// Compares LANES body segments against a target coordinate in parallel.
//   seg_x/seg_y : segment coordinates, one per lane
//   lane_en     : lane carries a live segment
//   tgt_x/tgt_y : coordinate under test
//   hit_c       : some enabled lane matches (combinational)
module snake_scan_lanes #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned COORD_W = 6
) (
  input  logic [COORD_W-1:0] seg_x [LANES],
  input  logic [COORD_W-1:0] seg_y [LANES],
  input  logic [LANES-1:0]   lane_en,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  output logic               hit_c
);

  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_en[i] && (seg_x[i] == tgt_x) && (seg_y[i] == tgt_y)) hit_c = 1'b1;
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body owner: circular coordinate buffer, move/grow steps and
// occupancy queries answered by a LANES-wide scan.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of snake_body_engine_if (requests, results, status)
module snake_body_engine #(
  parameter int unsigned MAX_LEN  = 100,
  parameter int unsigned COORD_W  = snake_pkg::COORD_W,
  parameter int unsigned X_MAX    = 63,
  parameter int unsigned Y_MAX    = 47,
  parameter int unsigned LANES    = 8,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned INIT_X   = 32,
  parameter int unsigned INIT_Y   = 24
) (
  input logic                clk,
  input logic                rst_n,
  snake_body_engine_if.slave bus
);
  import snake_pkg::*;

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t             state, state_d;
  logic [COORD_W-1:0] body_x [MAX_LEN];
  logic [COORD_W-1:0] body_y [MAX_LEN];
  logic [PTR_W-1:0]   head_ptr, ptr_dec;
  logic [LEN_W-1:0]   len_q, scan_base, scan_base_d, scan_len, cand_len;
  logic [COORD_W-1:0] hx_q, hy_q, tgt_x, tgt_y, cand_x, cand_y;
  logic               is_step_q, is_step_d, grow_q, grow_eff, dead_q, ready_q;
  logic               r_valid_q, r_is_step_q, r_wall_q, r_self_q;
  logic               acc_step, acc_q, cand_wall, res_wall_d, res_self_d;
  logic [COORD_W-1:0] lane_x [LANES];
  logic [COORD_W-1:0] lane_y [LANES];
  logic [LANES-1:0]   lane_en;
  logic               hit_c;

  // Buffer index of segment 'off' counted from the head, wrapped mod MAX_LEN.
  function automatic logic [PTR_W-1:0] seg_idx(input logic [PTR_W-1:0] base,
                                               input int unsigned off);
    int unsigned p;
    p = 32'(base) + off;
    if (p >= MAX_LEN) p = p - MAX_LEN;
    if (p >= MAX_LEN) p = 0;  // only reachable for disabled lanes
    return PTR_W'(p);
  endfunction

  assign ptr_dec = (head_ptr == '0) ? PTR_W'(MAX_LEN - 1) : head_ptr - PTR_W'(1);

  // Request arbitration and target/wall computation for the accept cycle.
  always_comb begin
    acc_step = 1'b0;
    acc_q    = 1'b0;
    cand_x   = bus.q_x;
    cand_y   = bus.q_y;
    if (state == ST_IDLE) begin
      if (bus.step_valid) begin
        acc_step = !dead_q;
        cand_x   = hx_q;
        cand_y   = hy_q;
        unique case (dir_t'(bus.step_dir))
          DIR_PX: cand_x = hx_q + COORD_W'(1);
          DIR_NX: cand_x = hx_q - COORD_W'(1);
          DIR_PY: cand_y = hy_q + COORD_W'(1);
          DIR_NY: cand_y = hy_q - COORD_W'(1);
        endcase
      end else begin
        acc_q = bus.q_valid;
      end
    end
    cand_wall = (32'(cand_x) >= X_MAX) || (cand_x == '0) ||
                (32'(cand_y) >= Y_MAX) || (cand_y == '0);
    grow_eff  = bus.step_grow && (32'(len_q) < MAX_LEN);
    // A plain move frees the tail cell, so the tail is excluded from the scan.
    cand_len  = (acc_step && !grow_eff) ? len_q - LEN_W'(1) : len_q;
  end

  // Next-state logic.
  always_comb begin
    state_d     = state;
    scan_base_d = scan_base;
    res_wall_d  = 1'b0;
    res_self_d  = 1'b0;
    is_step_d   = is_step_q;
    unique case (state)
      ST_IDLE: begin
        if (acc_step || acc_q) begin
          is_step_d   = acc_step;
          res_wall_d  = cand_wall;
          scan_base_d = '0;
          state_d     = (cand_wall || (cand_len == '0)) ? ST_RESULT : ST_SCAN;
        end
      end
      ST_SCAN: begin
        res_self_d  = hit_c;
        scan_base_d = LEN_W'(32'(scan_base) + LANES);
        if (hit_c || ((32'(scan_base) + LANES) >= 32'(scan_len))) state_d = ST_RESULT;
      end
      ST_RESULT: state_d = (is_step_q && !r_wall_q && !r_self_q) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Present the current window of LANES segments to the comparators.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_en[i] = (32'(scan_base) + i) < 32'(scan_len);
      lane_x[i]  = body_x[seg_idx(head_ptr, 32'(scan_base) + i)];
      lane_y[i]  = body_y[seg_idx(head_ptr, 32'(scan_base) + i)];
    end
  end

  snake_scan_lanes #(.LANES(LANES), .COORD_W(COORD_W)) u_scan (
    .seg_x   (lane_x),
    .seg_y   (lane_y),
    .lane_en (lane_en),
    .tgt_x   (tgt_x),
    .tgt_y   (tgt_y),
    .hit_c   (hit_c)
  );

  // State, body buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      head_ptr    <= '0;
      len_q       <= LEN_W'(INIT_LEN);
      hx_q        <= COORD_W'(INIT_X);
      hy_q        <= COORD_W'(INIT_Y);
      tgt_x       <= '0;
      tgt_y       <= '0;
      scan_base   <= '0;
      scan_len    <= '0;
      is_step_q   <= 1'b0;
      grow_q      <= 1'b0;
      dead_q      <= 1'b0;
      ready_q     <= 1'b1;
      r_valid_q   <= 1'b0;
      r_is_step_q <= 1'b0;
      r_wall_q    <= 1'b0;
      r_self_q    <= 1'b0;
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
        body_x[k] <= (k < INIT_LEN) ? COORD_W'(INIT_X - k) : '0;
        body_y[k] <= (k < INIT_LEN) ? COORD_W'(INIT_Y) : '0;
      end
    end else begin
      state       <= state_d;
      scan_base   <= scan_base_d;
      is_step_q   <= is_step_d;
      ready_q     <= (state_d == ST_IDLE);
      r_valid_q   <= (state_d == ST_RESULT);
      r_is_step_q <= (state_d == ST_RESULT) && is_step_d;
      r_wall_q    <= (state_d == ST_RESULT) && res_wall_d;
      r_self_q    <= (state_d == ST_RESULT) && res_self_d;
      if (acc_step || acc_q) begin
        tgt_x    <= cand_x;
        tgt_y    <= cand_y;
        scan_len <= cand_len;
        grow_q   <= acc_step && grow_eff;
      end
      if ((state == ST_RESULT) && is_step_q && (r_wall_q || r_self_q)) dead_q <= 1'b1;
      if (state == ST_COMMIT) begin
        head_ptr        <= ptr_dec;
        body_x[ptr_dec] <= tgt_x;
        body_y[ptr_dec] <= tgt_y;
        hx_q            <= tgt_x;
        hy_q            <= tgt_y;
        if (grow_q) len_q <= len_q + LEN_W'(1);
      end
    end
  end

  assign bus.step_ready = ready_q;
  assign bus.r_valid    = r_valid_q;
  assign bus.r_is_step  = r_is_step_q;
  assign bus.r_wall     = r_wall_q;
  assign bus.r_self     = r_self_q;
  assign bus.head_x     = hx_q;
  assign bus.head_y     = hy_q;
  assign bus.length     = len_q;
  assign bus.dead       = dead_q;

endmodule
